cache_bus_arbiter: RTL and testbench
====================================

# cache_bus_arbiter

Sits directly downstream of the split instruction/data caches. Merges their two SRAM-like miss/uncached request ports into a single SRAM-like port that feeds the AXI bridge. Handles one transaction at a time. Ties are resolved round-robin, and each response is steered back only to the cache that issued the request.

## Interface
- DATA_FIRST, 1: which master wins the first tie after reset (1 = data, 0 = inst).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cache_inst_req  in  1  instruction-side request; held until cache_inst_addr_ok.
- cache_inst_wr  in  1  instruction-side write flag.
- cache_inst_size  in  2  instruction-side size (0=byte, 1=half, 2=word).
- cache_inst_addr  in  32  instruction-side address.
- cache_inst_wdata  in  32  instruction-side write data.
- cache_inst_rdata  out  32  read data; equals mem_rdata.
- cache_inst_addr_ok  out  1  address accepted for the instruction side.
- cache_inst_data_ok  out  1  transaction complete for the instruction side.
- cache_data_req / _wr / _size / _addr / _wdata  in  1/1/2/32/32  data side; same meaning as the inst-side inputs.
- cache_data_rdata  out  32  read data; equals mem_rdata.
- cache_data_addr_ok  out  1  address accepted for the data side.
- cache_data_data_ok  out  1  transaction complete for the data side.
- mem_req  out  1  merged request to the AXI bridge.
- mem_wr  out  1  merged write flag.
- mem_size  out  2  merged size.
- mem_addr  out  32  merged address.
- mem_wdata  out  32  merged write data.
- mem_rdata  in  32  read data from the bridge.
- mem_addr_ok  in  1  bridge accepted the address.
- mem_data_ok  in  1  bridge completed the transaction; never asserted in the same cycle as the matching mem_addr_ok.

## Operation
- FSM states: IDLE, ADDR_I, ADDR_D, WAIT_I, WAIT_D. The state register, `last` (last master served), and nothing else are registered.
- IDLE, neither cache requesting: stay in IDLE.
- IDLE, one cache requesting: go to ADDR_I or ADDR_D for that cache.
- IDLE, both caches requesting: grant the master that is not `last`. `last` resets to the inverse of DATA_FIRST, so the first tie goes to DATA_FIRST's side.
- ADDR_x:
  - mem_req = cache_x_req.
  - mem_wr, mem_size, mem_addr, mem_wdata are driven combinationally from master x.
  - cache_x_addr_ok = mem_addr_ok.
  - On mem_req & mem_addr_ok: go to WAIT_x and set last <= x.
  - If cache_x_req drops without an addr_ok (abandoned request): go to IDLE and leave `last` unchanged.
- WAIT_x:
  - mem_req = 0.
  - cache_x_data_ok = mem_data_ok.
  - On mem_data_ok: go to IDLE.
- mem_data_ok in IDLE or ADDR_x is ignored; no data_ok is forwarded.
- Outside ADDR_x, mem_wr, mem_size, mem_addr, mem_wdata are driven to 0.
- The non-granted master's addr_ok and data_ok are always 0; its request waits.
- Both caches see mem_rdata on their rdata outputs unconditionally. Only data_ok qualifies it.
- Data passes through unmodified; there is no width or byte-lane manipulation.

## Timing
- Reset (asynchronous, takes effect immediately): state = IDLE, last = !DATA_FIRST. All outputs are 0 except the two rdata outputs, which follow mem_rdata.
- Arbitration latency: a request first seen in IDLE produces mem_req in the next cycle.
- Address handshake: combinational from mem_addr_ok to cache_x_addr_ok in the same cycle.
- Response: mem_data_ok to cache_x_data_ok is combinational, same cycle. The FSM returns to IDLE in the next cycle.
- Minimum back-to-back spacing: IDLE, ADDR, WAIT, IDLE. That is 3 cycles per transaction if the bridge answers immediately.
- Reset mid-transaction: the FSM drops to IDLE and no data_ok is ever issued for the in-flight transaction. The bridge is reset on the same rst.

## Test plan
- Single inst read: inst_req with addr 0xBFC0_0000; mem_addr_ok at cycle 2; mem_data_ok with rdata 0x1234_5678 at cycle 4. Required: mem_addr = 0xBFC0_0000 at cycle 1; inst_addr_ok at cycle 2; inst_data_ok with rdata 0x1234_5678 at cycle 4; data_* handshake outputs stay 0 throughout.
- Tie after reset (DATA_FIRST=1): both caches request in the same cycle. Required: data is granted first; inst is granted in the following IDLE; the next tie goes to data again (round-robin alternation).
- Data write pass-through: data side wr=1, size=1, addr 0x8000_0002, wdata 0xAAAA_5555. Required: mem_* carry exactly these values while in ADDR_D; mem_req = 0 in WAIT_D.
- Abandoned request: inst_req raised, then dropped in ADDR_I before any addr_ok. Required: FSM returns to IDLE; no addr_ok or data_ok issued; `last` unchanged.
- Stray mem_data_ok in IDLE. Required: no data_ok on either cache side.
- rst asserted in WAIT_D. Required: all handshake outputs are 0 immediately; the next data request restarts from IDLE.

Source files
------------

// File: rtl/cache_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_bus_arbiter
// Purpose  : Merges the instruction-cache and data-cache SRAM-like request
//            ports into one SRAM-like port toward the AXI bridge. One
//            transaction in flight at a time, round-robin on ties, responses
//            steered back only to the issuing cache.
// Revision : 1.0 - initial release
// ============================================================================
module cache_bus_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cache_inst_req,
  input  logic        cache_inst_wr,
  input  logic [1:0]  cache_inst_size,
  input  logic [31:0] cache_inst_addr,
  input  logic [31:0] cache_inst_wdata,
  output logic [31:0] cache_inst_rdata,
  output logic        cache_inst_addr_ok,
  output logic        cache_inst_data_ok,

  input  logic        cache_data_req,
  input  logic        cache_data_wr,
  input  logic [1:0]  cache_data_size,
  input  logic [31:0] cache_data_addr,
  input  logic [31:0] cache_data_wdata,
  output logic [31:0] cache_data_rdata,
  output logic        cache_data_addr_ok,
  output logic        cache_data_data_ok,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_ADDR_I = 3'd1;
  localparam logic [2:0] c_ADDR_D = 3'd2;
  localparam logic [2:0] c_WAIT_I = 3'd3;
  localparam logic [2:0] c_WAIT_D = 3'd4;

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  // 1 = data side was served last, 0 = instruction side
  logic       r_last;
  logic       w_last_next;

  // Next-state selection and round-robin bookkeeping
  always_comb begin
    w_next_state = r_state;
    w_last_next  = r_last;
    case (r_state)
      c_IDLE: begin
        if (cache_inst_req && cache_data_req) begin
          // Tie: the side not served last wins
          w_next_state = r_last ? c_ADDR_I : c_ADDR_D;
        end else if (cache_inst_req) begin
          w_next_state = c_ADDR_I;
        end else if (cache_data_req) begin
          w_next_state = c_ADDR_D;
        end
      end
      c_ADDR_I: begin
        if (!cache_inst_req) begin
          // Abandoned before acceptance: fairness history untouched
          w_next_state = c_IDLE;
        end else if (mem_addr_ok) begin
          w_next_state = c_WAIT_I;
          w_last_next  = 1'b0;
        end
      end
      c_ADDR_D: begin
        if (!cache_data_req) begin
          w_next_state = c_IDLE;
        end else if (mem_addr_ok) begin
          w_next_state = c_WAIT_D;
          w_last_next  = 1'b1;
        end
      end
      c_WAIT_I: begin
        if (mem_data_ok) w_next_state = c_IDLE;
      end
      c_WAIT_D: begin
        if (mem_data_ok) w_next_state = c_IDLE;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // State and last-served registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_last  <= !DATA_FIRST;
    end else begin
      r_state <= w_next_state;
      r_last  <= w_last_next;
    end
  end

  // Read data is broadcast; data_ok alone qualifies it
  assign cache_inst_rdata = mem_rdata;
  assign cache_data_rdata = mem_rdata;

  // Request muxing and handshake steering toward the granted cache
  always_comb begin
    mem_req            = 1'b0;
    mem_wr             = 1'b0;
    mem_size           = 2'd0;
    mem_addr           = 32'd0;
    mem_wdata          = 32'd0;
    cache_inst_addr_ok = 1'b0;
    cache_inst_data_ok = 1'b0;
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    case (r_state)
      c_ADDR_I: begin
        mem_req            = cache_inst_req;
        mem_wr             = cache_inst_wr;
        mem_size           = cache_inst_size;
        mem_addr           = cache_inst_addr;
        mem_wdata          = cache_inst_wdata;
        cache_inst_addr_ok = mem_addr_ok;
      end
      c_ADDR_D: begin
        mem_req            = cache_data_req;
        mem_wr             = cache_data_wr;
        mem_size           = cache_data_size;
        mem_addr           = cache_data_addr;
        mem_wdata          = cache_data_wdata;
        cache_data_addr_ok = mem_addr_ok;
      end
      c_WAIT_I: cache_inst_data_ok = mem_data_ok;
      c_WAIT_D: cache_data_data_ok = mem_data_ok;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_bus_arbiter
// Purpose  : Self-checking bench for cache_bus_arbiter. A transaction-level
//            reference model predicts the visible port activity each cycle;
//            predictions go into a queue and a monitor pops and compares them
//            whenever the DUT shows activity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_bus_arbiter;

  localparam bit DATA_FIRST = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  logic [31:0] w_inst_rdata, w_data_rdata, w_mem_addr, w_mem_wdata;
  logic        w_inst_addr_ok, w_inst_data_ok, w_data_addr_ok, w_data_data_ok;
  logic        w_mem_req, w_mem_wr;
  logic [1:0]  w_mem_size;

  cache_bus_arbiter #(.DATA_FIRST(DATA_FIRST)) dut (
    .clk(clk), .rst(rst),
    .cache_inst_req(inst_req), .cache_inst_wr(inst_wr), .cache_inst_size(inst_size),
    .cache_inst_addr(inst_addr), .cache_inst_wdata(inst_wdata),
    .cache_inst_rdata(w_inst_rdata), .cache_inst_addr_ok(w_inst_addr_ok),
    .cache_inst_data_ok(w_inst_data_ok),
    .cache_data_req(data_req), .cache_data_wr(data_wr), .cache_data_size(data_size),
    .cache_data_addr(data_addr), .cache_data_wdata(data_wdata),
    .cache_data_rdata(w_data_rdata), .cache_data_addr_ok(w_data_addr_ok),
    .cache_data_data_ok(w_data_data_ok),
    .mem_req(w_mem_req), .mem_wr(w_mem_wr), .mem_size(w_mem_size),
    .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  // Visible port activity: {req, wr, size, addr, wdata, iao, ido, dao, ddo}
  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        iao;
    logic        ido;
    logic        dao;
    logic        ddo;
  } pl_t;

  typedef struct {
    int  cyc;
    pl_t p;
  } ent_t;

  ent_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  // Reference model: who owns the bus (0 none, 1 inst, 2 data), whether the
  // address has been accepted, and whether data was the last side served.
  int   m_owner;
  bit   m_accepted;
  bit   m_last_data;
  ent_t last_exp;

  // Cache-side stimulus state
  bit   i_pend, d_pend, i_ack, d_ack;

  function automatic ent_t predict();
    ent_t e;
    e.cyc = cyc;
    e.p   = '0;
    if (!rst && m_owner != 0) begin
      if (!m_accepted) begin
        if (m_owner == 1) begin
          e.p.req = inst_req; e.p.wr = inst_wr; e.p.size = inst_size;
          e.p.addr = inst_addr; e.p.wdata = inst_wdata; e.p.iao = mem_addr_ok;
        end else begin
          e.p.req = data_req; e.p.wr = data_wr; e.p.size = data_size;
          e.p.addr = data_addr; e.p.wdata = data_wdata; e.p.dao = mem_addr_ok;
        end
      end else if (m_owner == 1) begin
        e.p.ido = mem_data_ok;
      end else begin
        e.p.ddo = mem_data_ok;
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    m_owner     = 0;
    m_accepted  = 1'b0;
    m_last_data = !DATA_FIRST;
  endtask

  // Advance the model by one clock using the inputs of the finished cycle
  task automatic model_update();
    bit owner_req;
    if (rst) begin
      model_reset();
    end else if (m_owner == 0) begin
      m_accepted = 1'b0;
      if (inst_req && data_req) m_owner = m_last_data ? 1 : 2;
      else if (inst_req)        m_owner = 1;
      else if (data_req)        m_owner = 2;
    end else if (!m_accepted) begin
      owner_req = (m_owner == 1) ? inst_req : data_req;
      if (!owner_req) begin
        m_owner = 0;
      end else if (mem_addr_ok) begin
        m_accepted  = 1'b1;
        m_last_data = (m_owner == 2);
      end
    end else if (mem_data_ok) begin
      m_owner    = 0;
      m_accepted = 1'b0;
    end
  endtask

  // Publish the prediction for the current cycle, then clock once
  task automatic cycle();
    ent_t e;
    if (rst) model_reset();
    e = predict();
    last_exp = e;
    if (e.p != '0) q.push_back(e);
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  // Randomized traffic with a reactive bridge; percentages per cycle
  task automatic run_random(input int n, input int p_new, input int p_ab,
                            input int p_ok, input int p_stray);
    ent_t e;
    for (int k = 0; k < n; k++) begin
      if (i_pend && i_ack) i_pend = 0;
      if (d_pend && d_ack) d_pend = 0;
      if (i_pend && $urandom_range(99) < p_ab) i_pend = 0;
      if (d_pend && $urandom_range(99) < p_ab) d_pend = 0;
      if (!i_pend) begin
        inst_wr = 1'($urandom); inst_size = 2'($urandom_range(2));
        inst_addr = $urandom; inst_wdata = $urandom;
        if ($urandom_range(99) < p_new) i_pend = 1;
      end
      if (!d_pend) begin
        data_wr = 1'($urandom); data_size = 2'($urandom_range(2));
        data_addr = $urandom; data_wdata = $urandom;
        if ($urandom_range(99) < p_new) d_pend = 1;
      end
      inst_req    = i_pend;
      data_req    = d_pend;
      mem_rdata   = $urandom;
      mem_addr_ok = 0;
      mem_data_ok = 0;
      e = predict();
      mem_addr_ok = e.p.req && ($urandom_range(99) < p_ok);
      if (m_owner != 0 && m_accepted)
        mem_data_ok = ($urandom_range(99) < p_ok);
      else if (!mem_addr_ok)
        mem_data_ok = ($urandom_range(99) < p_stray);
      cycle();
      i_ack = last_exp.p.iao;
      d_ack = last_exp.p.dao;
    end
  endtask

  // Monitor: compare predicted activity against the DUT away from the edge
  always @(negedge clk) begin : mon
    pl_t  act;
    ent_t e;
    bit   front;
    act = {w_mem_req, w_mem_wr, w_mem_size, w_mem_addr, w_mem_wdata,
           w_inst_addr_ok, w_inst_data_ok, w_data_addr_ok, w_data_data_ok};
    while (q.size() != 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      total++; bad++;
      $display("FAIL missed_activity cyc=%0d got=none want=%h", e.cyc, e.p);
    end
    front = (q.size() != 0) && (q[0].cyc == cyc);
    total++;
    if (front) begin
      e = q.pop_front();
      if (act !== e.p) begin
        bad++;
        $display("FAIL port_activity cyc=%0d got=%h want=%h", cyc, act, e.p);
      end
    end else if (act !== '0) begin
      bad++;
      $display("FAIL unexpected_activity cyc=%0d got=%h want=0", cyc, act);
    end
    total++;
    if (w_inst_rdata !== mem_rdata || w_data_rdata !== mem_rdata) begin
      bad++;
      $display("FAIL rdata_broadcast cyc=%0d got=%h/%h want=%h",
               cyc, w_inst_rdata, w_data_rdata, mem_rdata);
    end
  end

  initial begin
    idle_inputs();
    mem_rdata = 32'h0;
    rst = 1;
    model_reset();
    i_pend = 0; d_pend = 0; i_ack = 0; d_ack = 0;
    cycle(); cycle();
    rst = 0;
    cycle();

    // Single inst read: accepted one cycle after mem_req, answered two later
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2; inst_wr = 0;
    cycle();                                  // IDLE sees request
    cycle();                                  // ADDR_I, bridge not ready
    mem_addr_ok = 1; cycle();                 // address accepted
    inst_req = 0; mem_addr_ok = 0; cycle();   // WAIT_I
    mem_data_ok = 1; mem_rdata = 32'h1234_5678; cycle();
    mem_data_ok = 0; cycle();

    // Tie after reset history: data first, then inst, then data again
    i_pend = 1; d_pend = 1; i_ack = 0; d_ack = 0;
    run_random(7, 0, 0, 100, 0);
    i_pend = 1; d_pend = 1;
    run_random(8, 0, 0, 100, 0);

    // Data write pass-through
    idle_inputs();
    data_req = 1; data_wr = 1; data_size = 1;
    data_addr = 32'h8000_0002; data_wdata = 32'hAAAA_5555;
    cycle();
    cycle();
    mem_addr_ok = 1; cycle();
    idle_inputs(); cycle();                   // WAIT_D, mem_req low
    mem_data_ok = 1; cycle();
    mem_data_ok = 0; cycle();

    // Abandoned inst request, then a tie exposes the unchanged history
    inst_req = 1; inst_addr = 32'h0000_1000;
    cycle(); cycle();
    inst_req = 0; cycle(); cycle();
    i_pend = 1; d_pend = 1; i_ack = 0; d_ack = 0;
    run_random(8, 0, 0, 100, 0);

    // Stray data_ok while idle
    idle_inputs();
    mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF; cycle();
    mem_data_ok = 0; cycle();

    // Reset while waiting on the data side, then restart
    data_req = 1; data_addr = 32'h0000_2000;
    cycle();
    mem_addr_ok = 1; cycle();
    data_req = 0; mem_addr_ok = 0;
    rst = 1; mem_data_ok = 1; cycle();        // asserted mid-WAIT_D
    rst = 0; mem_data_ok = 0; cycle();
    data_req = 1; data_addr = 32'h0000_3000;
    cycle(); mem_addr_ok = 1; cycle();
    idle_inputs(); mem_data_ok = 1; cycle();
    mem_data_ok = 0; cycle();

    // Randomized traffic
    i_pend = 0; d_pend = 0; i_ack = 0; d_ack = 0;
    run_random(3000, 30, 5, 60, 10);
    idle_inputs();
    i_pend = 0; d_pend = 0;
    for (int k = 0; k < 10; k++) begin
      if (m_owner != 0 && m_accepted) mem_data_ok = 1;
      cycle();
      mem_data_ok = 0;
    end

    @(negedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover_predictions got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
